sistema_pio_in_edge: RTL and testbench

Parametrised Avalon-MM input port with metastability synchronisers, per-bit edge capture, an interrupt mask and a level interrupt. Next generation of the system's read-only input PIO: it adds configurable width, configurable edge sensitivity and a CPU interrupt path. It sits between asynchronous board inputs (switches, I2C status lines, buttons) and the Nios II data master.

---
 rtl/sistema_pio_in_edge.sv | 202 ++++++++++++++++++++
 tb/tb_sistema_pio_in_edge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_pio_in_edge.sv
// sistema_pio_in_edge
// ---------------------------------------------------------------------------
// Avalon-MM read-mostly input port for the Nios II data master. Asynchronous
// board inputs are passed through a per-bit synchroniser chain. Each bit has
// an edge detector (rising, falling or any edge). Detected edges are held in a
// sticky EDGECAPTURE register that the CPU clears by writing 1s. A level
// interrupt is raised when any captured bit is also enabled in IRQMASK.
//
// Register map (word addresses):
//   0 DATA        RO   synchronised input value
//   1 reserved         reads 0, writes ignored
//   2 IRQMASK     RW   interrupt enable per bit (only with the IRQ macro)
//   3 EDGECAPTURE R/W1C sticky edge flags
//
// Configuration macro: SISTEMA_PIO_IN_IRQ_EN
//   defined   -> IRQMASK register and irq logic are present
//   undefined -> address 2 reads 0, writes to it are ignored, irq is 0
//
// Parameters:
//   WIDTH       input port width, 1..32
//   EDGE_TYPE   0 = rising, 1 = falling, 2 = any edge
//   SYNC_STAGES synchroniser depth, 2..4
//
// Ports:
//   clk         system clock, the only clock
//   reset       synchronous active-high reset
//   address     Avalon word address
//   chipselect  Avalon select, qualifies writes
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, zero-extended from WIDTH
//   irq         level interrupt to the CPU
// ---------------------------------------------------------------------------
module sistema_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge detection is held off until the synchroniser and prev_q have been
  // refilled with real input samples after reset; the last warm-up edge is
  // the one where the counter already holds SYNC_STAGES.
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

  typedef enum logic {
    WARMUP,
    ARMED
  } arm_state_t;

  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata_port;
  logic [WIDTH-1:0] w1c_clear;
  logic [WIDTH-1:0] edge_set;
  logic [31:0]      read_mux;
  logic [2:0]       arm_count;
  arm_state_t       arm_state;
  logic             wr_en;

  assign wr_en      = chipselect & ~write_n;
  assign wdata_port = writedata[WIDTH-1:0];

  // Upper writedata bits have no register behind them for narrow ports.
  generate
    if (WIDTH < 32) begin : g_wdata_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  // Synchroniser chain plus the one-cycle delayed copy used for edge
  // detection. All stages are cleared so no stale pre-reset value survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      prev_q <= sync_q;
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Edge sensitivity is fixed at elaboration time.
  generate
    if (EDGE_TYPE == 1) begin : g_falling
      assign edge_det = ~sync_q & prev_q;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign edge_det = sync_q ^ prev_q;
    end else begin : g_rising
      assign edge_det = sync_q & ~prev_q;
    end
  endgenerate

  // Arming FSM: counts clock edges after reset and then stays ARMED until
  // the next reset. While in WARMUP detected edges are ignored, which keeps
  // an input that is already high out of reset from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_state <= WARMUP;
      arm_count <= '0;
    end else begin
      case (arm_state)
        WARMUP: begin
          if (arm_count == ARM_LAST) begin
            arm_state <= ARMED;
          end else begin
            arm_count <= arm_count + 3'd1;
          end
        end
        ARMED: begin
          arm_state <= ARMED;
        end
        default: begin
          arm_state <= WARMUP;
          arm_count <= '0;
        end
      endcase
    end
  end

  assign edge_set  = (arm_state == ARMED) ? edge_det : '0;
  assign w1c_clear = (wr_en && (address == ADDR_EDGE)) ? wdata_port : '0;

  // Sticky edge flags. The set term is OR-ed in after the clear so that an
  // edge arriving on the same edge as a W1C of that bit keeps the bit at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~w1c_clear) | edge_set;
    end
  end

`ifdef SISTEMA_PIO_IN_IRQ_EN
  // Interrupt enable register; a write is visible to irq right after the
  // write edge because irq is formed directly from the two registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (address == ADDR_MASK)) begin
      irq_mask <= wdata_port;
    end
  end

  // Only registers feed irq, so there is no path from in_port to irq.
  assign irq = |(edge_capture & irq_mask);
`else
  // Without the interrupt path the mask reads back as zero.
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // Read mux; narrow registers are zero-extended to the 32-bit bus.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux = 32'(sync_q);
      ADDR_RSVD: read_mux = '0;
      ADDR_MASK: read_mux = 32'(irq_mask);
      ADDR_EDGE: read_mux = 32'(edge_capture);
      default:   read_mux = '0;
    endcase
  end

  // Read data is registered every cycle whether or not chipselect is high,
  // giving a fixed one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_sistema_pio_in_edge.sv
// tb_sistema_pio_in_edge
// ---------------------------------------------------------------------------
// Self-checking bench for sistema_pio_in_edge. Three instances share the bus
// and input stimulus, one per edge sensitivity (rising, falling, any). A
// time-indexed model of the input history predicts readdata and irq for each
// instance, and a compare process checks them on every falling clock edge.
// Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_sistema_pio_in_edge;

  localparam int S    = 2;
  localparam int MAXE = 4096;
`ifdef SISTEMA_PIO_IN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] rd_rise, rd_fall, rd_any;
  logic        irq_rise, irq_fall, irq_any;

  int checks   = 0;
  int failures = 0;

  sistema_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  sistema_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_fall), .irq(irq_fall)
  );

  sistema_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: samples of in_port at every clock edge, the index of the
  // latest reset edge, and the predicted register/output values.
  logic [7:0]  samp [MAXE];
  int          edge_n   = 0;
  int          rst_edge = 0;
  bit          m_valid  = 1'b0;
  logic [7:0]  m_cap  [3];
  logic [7:0]  m_mask;
  logic [31:0] m_rd   [3];
  logic        m_irq  [3];

  // Synchronised value after edge m is the input sampled S-1 edges earlier,
  // or 0 if that sample was taken at or before the latest reset edge.
  function automatic logic [7:0] syncAfter(input int m);
    int idx;
    idx = m - S + 1;
    if (idx > rst_edge && idx >= 0 && idx < MAXE) return samp[idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] edgesOf(input int kind, input logic [7:0] s,
                                         input logic [7:0] p);
    if (kind == 0) return s & ~p;
    if (kind == 1) return ~s & p;
    return s ^ p;
  endfunction

  // Model update at every rising edge, using the inputs presented before it.
  initial begin
    logic [7:0] s, p, clr;
    bit         wr, armed;
    forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
      if (edge_n < MAXE) samp[edge_n] = in_port;
      if (reset) begin
        rst_edge = edge_n;
        m_valid  = 1'b1;
        m_mask   = 8'h00;
        for (int k = 0; k < 3; k++) begin
          m_cap[k] = 8'h00;
          m_rd[k]  = 32'h0;
        end
      end else if (m_valid) begin
        s     = syncAfter(edge_n - 1);
        p     = syncAfter(edge_n - 2);
        wr    = chipselect && !write_n;
        armed = (edge_n - rst_edge) >= S + 2;
        clr   = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < 3; k++) begin
          case (address)
            2'd0:    m_rd[k] = {24'h0, s};
            2'd2:    m_rd[k] = {24'h0, m_mask};
            2'd3:    m_rd[k] = {24'h0, m_cap[k]};
            default: m_rd[k] = 32'h0;
          endcase
          m_cap[k] = (m_cap[k] & ~clr) | (armed ? edgesOf(k, s, p) : 8'h00);
        end
        if (IRQ_EN && wr && address == 2'd2) m_mask = writedata[7:0];
      end
      for (int k = 0; k < 3; k++) m_irq[k] = IRQ_EN && ((m_cap[k] & m_mask) != 8'h00);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("cyc_rd_rise",  rd_rise,          m_rd[0]);
        checkOutput("cyc_rd_fall",  rd_fall,          m_rd[1]);
        checkOutput("cyc_rd_any",   rd_any,           m_rd[2]);
        checkOutput("cyc_irq_rise", {31'h0, irq_rise}, {31'h0, m_irq[0]});
        checkOutput("cyc_irq_fall", {31'h0, irq_fall}, {31'h0, m_irq[1]});
        checkOutput("cyc_irq_any",  {31'h0, irq_any},  {31'h0, m_irq[2]});
      end
    end
  end

  // Presents one cycle of stimulus just after a rising edge; it is sampled
  // on the following rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [1:0] a, input logic [31:0] d,
                               input logic [7:0] p);
    @(posedge clk);
    #1;
    reset      = r;
    chipselect = c;
    write_n    = w;
    address    = a;
    writedata  = d;
    in_port    = p;
  endtask

  task automatic idle(input logic [1:0] a, input logic [7:0] p, input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, a, 32'h0, p);
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    writedata  = 32'h0;
    in_port    = 8'hFF;

    // Scenario 1: input high through reset must not produce a capture.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("s1_cap_rise", rd_rise, 32'h0);
    checkOutput("s1_cap_any",  rd_any,  32'h0);
    checkOutput("s1_irq_rise", {31'h0, irq_rise}, 32'h0);

    // Falling input on all bits: falling and any instances capture 8'hFF.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s1_fall_all", rd_fall, 32'h0000_00FF);
    checkOutput("s1_rise_none", rd_rise, 32'h0);

    // Scenario 2: clear, mask bit 0, rising edge on bit 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h01, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  8'h01);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("s2_irq_early", {31'h0, irq_rise}, 32'h0);
    @(posedge clk);
    #2;
    checkOutput("s2_data",      rd_rise, 32'h0000_0001);
    checkOutput("s2_irq",       {31'h0, irq_rise}, {31'h0, IRQ_EN});
    checkOutput("s2_model_cap", {24'h0, m_cap[0]}, 32'h0000_0001);

    // Scenario 3: W1C drops irq right after the write edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'h1, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h01);
    @(negedge clk);
    checkOutput("s3_irq_w1c", {31'h0, irq_rise}, 32'h0);

    // New rising edge captured on the same edge as a W1C of bit 0.
    idle(2'd3, 8'h00, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'h1, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h01);
    @(negedge clk);
    checkOutput("s3_irq_edgewins", {31'h0, irq_rise}, {31'h0, IRQ_EN});
    @(posedge clk);
    #2;
    checkOutput("s3_cap_edgewins", rd_rise, 32'h0000_0001);

    // Scenario 4: falling edge 8'h80 -> 8'h00.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h01);
    idle(2'd3, 8'h80, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h80);
    idle(2'd3, 8'h80, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s4_fall_80", rd_fall, 32'h0000_0080);

    // Any-edge: toggle bit 3 twice with a clear in between.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h00);
    idle(2'd3, 8'h00, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h08);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s4_any_up", rd_any, 32'h0000_0008);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'h08, 8'h08);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0,  8'h08);
    @(posedge clk);
    #2;
    checkOutput("s4_any_clr", rd_any, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s4_any_down", rd_any, 32'h0000_0008);

    // Scenario 5: mask 0 keeps irq low; mask 8'h04 raises it next cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h00, 8'h00);
    idle(2'd3, 8'h00, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'h04);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s5_cap_bit2",  rd_rise, 32'h0000_0004);
    checkOutput("s5_irq_mask0", {31'h0, irq_rise}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h04, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'h0,  8'h04);
    @(negedge clk);
    checkOutput("s5_irq_mask4", {31'h0, irq_rise}, {31'h0, IRQ_EN});
    @(posedge clk);
    #2;
    checkOutput("s5_rsvd", rd_rise, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 8'h04);
    @(posedge clk);
    #2;
    checkOutput("s5_mask_rd", rd_rise, IRQ_EN ? 32'h0000_0004 : 32'h0);

    // Scenario 6: any-edge capture of all bits, then reset mid-operation.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 32'hFF, 8'h04);
    idle(2'd3, 8'h04, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'hFB);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s6_any_ff", rd_any, 32'h0000_00FF);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 32'h0, 8'hFB);
    @(posedge clk);
    #2;
    checkOutput("s6_rst_rd_rise", rd_rise, 32'h0);
    checkOutput("s6_rst_rd_any",  rd_any,  32'h0);
    checkOutput("s6_rst_irq_any", {31'h0, irq_any}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 8'hFB);
    idle(2'd3, 8'hFB, 10);
    @(posedge clk);
    #2;
    checkOutput("s6_post_cap_any", rd_any, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 8'hFB);
    @(posedge clk);
    #2;
    checkOutput("s6_post_mask", rd_rise, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
